// File: rtl/change_payout_ctrl.sv
// Greedy coin-return sequencer: pays change from $1/$0.50/$0.25 tubes, one acknowledged eject at a time.
// Optional CHANGE_PAYOUT_PRECHECK_EN adds a PRECHECK state that faults before any eject if the payout cannot complete.
module change_payout_ctrl #(
    parameter int AMT_W       = 16,
    parameter int INV_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             in_clka,
    input  logic             in_restart_n,
    input  logic             in_start,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             in_load,
    input  logic [INV_W-1:0] in_load_1,
    input  logic [INV_W-1:0] in_load_05,
    input  logic [INV_W-1:0] in_load_025,
    input  logic             in_eject_ack,
    output logic             out_eject_1,
    output logic             out_eject_05,
    output logic             out_eject_025,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_fault,
    output logic [AMT_W-1:0] out_remaining,
    output logic [INV_W-1:0] out_inv_1,
    output logic [INV_W-1:0] out_inv_05,
    output logic [INV_W-1:0] out_inv_025,
    output logic [2:0]       out_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_EJECT    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_FAULT    = 3'd5,
        S_PRECHECK = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_1    = 2'd1,
        COIN_05   = 2'd2,
        COIN_025  = 2'd3
    } coin_t;

    localparam int              TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    coin_t              r_coin;
    coin_t              w_pick;
    logic [AMT_W-1:0]   r_remaining;
    logic [INV_W-1:0]   r_inv_1;
    logic [INV_W-1:0]   r_inv_05;
    logic [INV_W-1:0]   r_inv_025;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_fault;

    logic w_start_ok;
    logic w_load_ok;
    logic w_ack_take;
    logic w_eject_active;

    // A simultaneous load wins over start so inventory is never stale when payout begins.
    assign w_load_ok      = (r_state == S_IDLE) && in_load;
    assign w_start_ok     = (r_state == S_IDLE) && in_start && !in_load;
    assign w_ack_take     = in_eject_ack && ((r_state == S_EJECT) || (r_state == S_WAIT_ACK));
    assign w_eject_active = (r_state == S_EJECT) || (r_state == S_WAIT_ACK);

`ifdef CHANGE_PAYOUT_PRECHECK_EN
    localparam int CW = ((AMT_W > INV_W) ? AMT_W : INV_W) + 2;

    logic [CW-1:0] w_amt, w_t1, w_d, w_r1, w_t2, w_h, w_r2, w_q, w_r3;
    logic          w_pre_ok;

    // Full greedy dry run against current inventory; residue must be zero to proceed.
    assign w_amt    = CW'(r_remaining);
    assign w_t1     = w_amt >> 2;
    assign w_d      = (CW'(r_inv_1) < w_t1) ? CW'(r_inv_1) : w_t1;
    assign w_r1     = w_amt - (w_d << 2);
    assign w_t2     = w_r1 >> 1;
    assign w_h      = (CW'(r_inv_05) < w_t2) ? CW'(r_inv_05) : w_t2;
    assign w_r2     = w_r1 - (w_h << 1);
    assign w_q      = (CW'(r_inv_025) < w_r2) ? CW'(r_inv_025) : w_r2;
    assign w_r3     = w_r2 - w_q;
    assign w_pre_ok = (w_r3 == '0);
`endif

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        w_next = r_state;
        w_pick = COIN_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
`ifdef CHANGE_PAYOUT_PRECHECK_EN
                    w_next = S_PRECHECK;
`else
                    w_next = S_SELECT;
`endif
                end
            end
`ifdef CHANGE_PAYOUT_PRECHECK_EN
            S_PRECHECK: w_next = w_pre_ok ? S_SELECT : S_FAULT;
`endif
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_next = S_DONE;
                end else if ((r_remaining >= AMT_W'(4)) && (r_inv_1 != '0)) begin
                    w_pick = COIN_1;
                    w_next = S_EJECT;
                end else if ((r_remaining >= AMT_W'(2)) && (r_inv_05 != '0)) begin
                    w_pick = COIN_05;
                    w_next = S_EJECT;
                end else if (r_inv_025 != '0) begin
                    w_pick = COIN_025;
                    w_next = S_EJECT;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_EJECT: w_next = in_eject_ack ? S_SELECT : S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (in_eject_ack) begin
                    w_next = S_SELECT;
                end else if (r_tmo == TMO_LAST) begin
                    w_next = S_FAULT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            r_coin      <= COIN_NONE;
            r_remaining <= '0;
            r_inv_1     <= '0;
            r_inv_05    <= '0;
            r_inv_025   <= '0;
            r_tmo       <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (w_load_ok) begin
                r_inv_1   <= in_load_1;
                r_inv_05  <= in_load_05;
                r_inv_025 <= in_load_025;
            end
            if (w_start_ok) begin
                r_remaining <= in_amount;
                r_fault     <= 1'b0;
            end
            if (r_state == S_SELECT) begin
                r_coin <= w_pick;
            end
            if (r_state == S_EJECT) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT_ACK) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            // Only an acknowledged coin is deducted; selection guarantees no underflow.
            if (w_ack_take) begin
                case (r_coin)
                    COIN_1: begin
                        r_remaining <= r_remaining - AMT_W'(4);
                        r_inv_1     <= r_inv_1 - INV_W'(1);
                    end
                    COIN_05: begin
                        r_remaining <= r_remaining - AMT_W'(2);
                        r_inv_05    <= r_inv_05 - INV_W'(1);
                    end
                    COIN_025: begin
                        r_remaining <= r_remaining - AMT_W'(1);
                        r_inv_025   <= r_inv_025 - INV_W'(1);
                    end
                    default: ;
                endcase
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign out_eject_1   = w_eject_active && (r_coin == COIN_1);
    assign out_eject_05  = w_eject_active && (r_coin == COIN_05);
    assign out_eject_025 = w_eject_active && (r_coin == COIN_025);
    assign out_busy      = (r_state != S_IDLE);
    assign out_done      = (r_state == S_DONE);
    assign out_fault     = r_fault;
    assign out_remaining = r_remaining;
    assign out_inv_1     = r_inv_1;
    assign out_inv_05    = r_inv_05;
    assign out_inv_025   = r_inv_025;
    assign out_state     = r_state;

endmodule
